shift_add_mult4: RTL
====================

# shift_add_mult4

Sequential 4x4 unsigned multiplier built around one instance of the team's 4-bit `inferred_adder`. It sits directly upstream of that adder: each cycle it computes the adder's `A`/`B`/`cin` inputs and consumes `Y`/`cout` to form the next partial product. A full product takes four iterations. Operands are captured under a start/done handshake and the 8-bit result is held until the next operation completes.

## Interface
- No parameters. Operand width is fixed at 4 by the adder slice.
- `clk` input 1: single clock. All state changes on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request. Sampled only in IDLE.
- `a` input 4: multiplicand, unsigned. Captured on the accepting edge.
- `b` input 4: multiplier, unsigned. Captured on the accepting edge.
- `busy` output 1: high while an operation is in progress (RUN or DONE).
- `done` output 1: one-cycle pulse when `product` is updated.
- `product` output 8: `a*b` of the most recent completed operation.

## Operation
- Registers:
  - `mcand[3:0]`
  - `acc[3:0]`, the upper partial product
  - `mq[3:0]`, the multiplier / lower product
  - `cnt[1:0]`
  - `state` ∈ {IDLE, RUN, DONE}
  - `product[7:0]`
  - `done`
- Adder wiring, one `inferred_adder` instance:
  - `A` = `acc`
  - `B` = `mq[0]` ? `mcand` : 4'h0
  - `cin` = 0
- IDLE:
  - If `start` = 1: load `mcand`←`a`, `mq`←`b`, `acc`←0, `cnt`←0, then go to RUN.
  - Otherwise hold.
- RUN, one iteration per cycle:
  - Compute `{c, s}` = {`cout`, `Y`}.
  - Shift right: `{acc, mq}` ← `{c, s, mq[3:1]}`.
  - `cnt`←`cnt`+1.
  - When `cnt` = 3 on this edge, also load `product` ← `{c, s, mq[3:1]}` (the post-shift value), set `done`←1, and go to DONE.
- DONE:
  - Next edge: `done`←0, go to IDLE.
  - `start` is ignored in DONE.
- Width rules:
  - All arithmetic is unsigned and modulo-free. The 8-bit product never overflows: 15*15 = 225 = 8'hE1.
  - The adder's `cout` becomes the MSB shifted into `acc[3]`; it is never dropped.
- `start` while `busy` = 1 is ignored, not queued. Changes on `a`/`b` after acceptance have no effect.
- `product` is held, unchanged, from one DONE to the next. It updates only on the edge entering DONE.
- Reset, asynchronous, at any time including mid-RUN:
  - `state`=IDLE
  - `busy`=0
  - `done`=0
  - `product`=8'h00
  - `acc`, `mq`, `mcand`, `cnt` = 0
  - No partial result is ever published.

## Timing
- Reset values: `busy`=0, `done`=0, `product`=0.
- `busy` = (`state` != IDLE), decoded combinationally from the state register.
- Let edge E0 accept `start`. RUN occupies cycles E0..E3. Edge E4 is the 4th iteration and enters DONE.
- After edge E4: `done`=1 and `product` is valid. After edge E5: `done`=0 and `busy`=0.
- Latency from the accepting edge to `done` rising is 4 clocks. Throughput is one product per 6 clocks when `start` is held high: the accept edge, 3 further RUN edges, the DONE edge, and one IDLE sample.
- The adder path (`acc`/`mq[0]`/`mcand` → `Y`/`cout` → register) is the only combinational path and must close in one cycle.
- Release of `rst` is treated synchronously to `clk` by upstream logic. The first edge after release may accept `start`.

## Test plan
- Reset then `a`=4'hF, `b`=4'hF, `start` pulse: `done` rises exactly 4 edges after acceptance, `product`=8'hE1, `busy` falls one cycle later.
- `a`=4'h0, `b`=4'h9, then `a`=4'h7, `b`=4'h0: `product`=8'h00 both times. Latency is still 4 cycles.
- Exhaustive sweep of all 256 (`a`,`b`) pairs: each `product` equals `a*b`, and `done` pulses exactly once per operation.
- `start` held high continuously with `a`=3, `b`=5, then `a`=12, `b`=11: back-to-back products 8'h0F then 8'h84. Each `done` is one cycle wide, with 6-cycle spacing.
- Change `a`/`b` and pulse `start` while `busy`=1: ignored. The result matches the originally captured operands and there is no extra `done`.
- Assert `rst` during RUN (after 2 iterations of 9*13): outputs go to 0 immediately, no `done` appears, and a fresh 9*13 gives 8'h75.

Source files
------------

// File: rtl/shift_add_mult4.sv
// ============================================================================
// Module   : shift_add_mult4 (with 4-bit inferred_adder slice)
// Brief    : Sequential 4x4 unsigned shift-and-add multiplier, 4 iterations.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module inferred_adder (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       cin,
    output logic [3:0] Y,
    output logic       cout
);
    assign {cout, Y} = {1'b0, A} + {1'b0, B} + {4'b0000, cin};
endmodule

module shift_add_mult4 (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       busy,
    output logic       done,
    output logic [7:0] product
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;

    logic [3:0] mcand;
    logic [3:0] acc;
    logic [3:0] mq;
    logic [1:0] cnt;

    logic [3:0] add_b;
    logic [3:0] add_y;
    logic       add_cout;
    logic [7:0] shifted;
    logic       last_iter;

    assign add_b     = mq[0] ? mcand : 4'h0;
    assign shifted   = {add_cout, add_y, mq[3:1]};
    assign last_iter = (state == RUN) && (cnt == 2'd3);
    assign busy      = (state != IDLE);

    inferred_adder u_adder (
        .A    (acc),
        .B    (add_b),
        .cin  (1'b0),
        .Y    (add_y),
        .cout (add_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == 2'd3) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The adder carry enters acc[3] on every shift, so no product bit is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand   <= 4'h0;
            acc     <= 4'h0;
            mq      <= 4'h0;
            cnt     <= 2'd0;
            product <= 8'h00;
            done    <= 1'b0;
        end else begin
            done <= last_iter;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand <= a;
                        mq    <= b;
                        acc   <= 4'h0;
                        cnt   <= 2'd0;
                    end
                end
                RUN: begin
                    {acc, mq} <= shifted;
                    cnt       <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        product <= shifted;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

`default_nettype wire
